// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller:
// the FSM state encoding used by serial_add_ctrl.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/fa_mux_cell.sv
// Combinational 1-bit full adder built from two 4:1 muxes.
// {i_a,i_b} select among data inputs derived from the carry-in:
//   sum   : 00->c, 01->~c, 10->~c, 11->c
//   carry : 00->0, 01->c,  10->c,  11->1
module fa_mux_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic [3:0] w_sum_data;
  logic [3:0] w_carry_data;
  logic [1:0] w_sel;

  // NOTE: pure continuous assigns; every output is fully defined, so no latch can form.
  assign w_sel        = {i_a, i_b};
  assign w_sum_data   = {i_c, ~i_c, ~i_c, i_c};
  assign w_carry_data = {1'b1, i_c, i_c, 1'b0};

  assign o_s = w_sum_data[w_sel];
  assign o_c = w_carry_data[w_sel];

endmodule : fa_mux_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fa_mux_cell time-shared across WIDTH-bit
// operands, LSB first, one bit per clock, with a carry flop between bits.
// start/busy/done handshake; start -> done latency is WIDTH+1 cycles.
// Optional feature macro SERIAL_ADD_SUB_EN: adds a 'sub' input; when set on
// the accepted start the B stream is inverted and the carry preset to 1,
// giving a-b mod 2^WIDTH with cout=1 meaning no borrow.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  import serial_add_pkg::*;

  // Counter width is derived from WIDTH and is not meant to be overridden.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;

  logic               w_b_bit;
  logic               w_carry_ld;
  logic               w_s;
  logic               w_c;
  logic               w_last;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  logic r_sub;

  // Subtract mode: invert B bit-by-bit as it streams and preset the carry.
  assign w_b_bit    = r_b_sh[0] ^ r_sub;
  assign w_carry_ld = sub ? 1'b1 : cin;

  // Capture the operation mode together with the operands on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (start && (r_state == S_IDLE || r_state == S_DONE)) begin
      r_sub <= sub;
    end
  end
`else
  assign w_b_bit    = r_b_sh[0];
  assign w_carry_ld = cin;
`endif

  fa_mux_cell u_fa (
    .i_a (r_a_sh[0]),
    .i_b (w_b_bit),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // Sequencer: FSM, operand shift registers, carry flop, bit counter and
  // registered handshake outputs, all advanced together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register sees pre-edge values of the others.
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= w_carry_ld;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_c;
          r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8). Expected results come
// from plain integer arithmetic on the operands; the expected latency is
// WIDTH+1 cycles from the accepted start.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout,sum} as the unsigned (W+1)-bit result.
  function automatic logic [W:0] ref_result(input int ua, input int ub,
                                            input int ucin, input int usub);
    int r;
    if (usub != 0) r = ua + ((1 << W) - 1 - ub) + 1;
    else           r = ua + ub + ucin;
    return (W+1)'(r);
  endfunction

  // Drive one start at the next negedge, then wait (bounded) for done.
  // Returns the latency in cycles and the result seen in the done cycle.
  task automatic launch_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tcin, input logic tsub,
                                 output int lat, output logic [W-1:0] rs,
                                 output logic rc);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start: got %b want 1", busy);
    end
    while (done !== 1'b1 && lat < W + 6) begin
      @(negedge clk);
      lat++;
    end
    rs = sum;
    rc = cout;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input logic tcin, input logic tsub);
    int lat; logic [W-1:0] rs; logic rc; logic [W:0] exp;
    exp = ref_result(int'(ta), int'(tb), int'(tcin), int'(tsub));
    launch_and_wait(ta, tb, tcin, tsub, lat, rs, rc);
    n_checks++;
    if (lat !== W + 1) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, W + 1);
    end
    n_checks++;
    if ({rc, rs} !== exp) begin
      n_fail++; $display("FAIL %s result: got cout=%b sum=%h want cout=%b sum=%h",
                         name, rc, rs, exp[W], exp[W-1:0]);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_in_done: got %b want 0", name, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || {cout, sum} !== exp) begin
      n_fail++; $display("FAIL %s hold_after_done: got done=%b cout=%b sum=%h want done=0 cout=%b sum=%h",
                         name, done, cout, sum, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, cout, sum} !== '0) begin
      n_fail++; $display("FAIL reset_values: got busy=%b done=%b cout=%b sum=%h want all 0",
                         busy, done, cout, sum);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_add();
    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_carry_chain();
    run_op("carry_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("carry_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op("zero_c1", 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic tsub;
`ifdef SERIAL_ADD_SUB_EN
      tsub = 1'($urandom);
`else
      tsub = 1'b0;
`endif
      run_op("random", W'($urandom), W'($urandom), 1'($urandom), tsub);
    end
  endtask

  // A second start during RUN must be ignored and produce no extra done.
  task automatic test_start_ignored();
    int dones; int lat; int cyc; logic [W-1:0] rs; logic rc; logic [W:0] exp;
    exp = ref_result(8'h3C, 8'h55, 0, 0);
    dones = 0; lat = 0; rs = '0; rc = 1'b0;
    @(negedge clk);
    a = 8'h3C; b = 8'h55; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (cyc = 1; cyc <= W + 6; cyc++) begin
      @(negedge clk);
      start = (cyc == 3);
      a = 8'hAA; b = 8'hAA; cin = 1'b1; sub = 1'b1;
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) begin lat = cyc; rs = sum; rc = cout; end
      end
    end
    start = 1'b0;
    n_checks++;
    if (dones !== 1) begin
      n_fail++; $display("FAIL ignored_start done_count: got %0d want 1", dones);
    end
    n_checks++;
    if (lat !== W + 1 || {rc, rs} !== exp) begin
      n_fail++; $display("FAIL ignored_start result: got lat=%0d cout=%b sum=%h want lat=%0d cout=%b sum=%h",
                         lat, rc, rs, W + 1, exp[W], exp[W-1:0]);
    end
  endtask

  // Reset asserted mid-RUN aborts with no done; a fresh start then works.
  task automatic test_reset_mid_run();
    int dones;
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, cout, sum} !== '0) begin
      n_fail++; $display("FAIL midrun_reset: got busy=%b done=%b cout=%b sum=%h want all 0",
                         busy, done, cout, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset no_done: got dones=%0d busy=%b want 0 0", dones, busy);
    end
    run_op("after_reset", 8'h77, 8'h11, 1'b1, 1'b0);
  endtask

  // start held in the DONE cycle is accepted; results clear on the next edge.
  task automatic test_back_to_back();
    int lat; logic [W-1:0] rs; logic rc; logic [W:0] exp1;
    exp1 = ref_result(8'hA0, 8'h0B, 0, 0);
    launch_and_wait(8'hA0, 8'h0B, 1'b0, 1'b0, lat, rs, rc);
    n_checks++;
    if (lat !== W + 1 || {rc, rs} !== exp1) begin
      n_fail++; $display("FAIL b2b first: got lat=%0d cout=%b sum=%h want lat=%0d cout=%b sum=%h",
                         lat, rc, rs, W + 1, exp1[W], exp1[W-1:0]);
    end
    // Still inside the DONE cycle: raise start before the closing edge.
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, done, cout, sum} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL b2b cleared: got busy=%b done=%b cout=%b sum=%h want 1 0 0 00",
                         busy, done, cout, sum);
    end
    lat = 1;
    while (done !== 1'b1 && lat < W + 6) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== W + 1 || {cout, sum} !== {1'b0, 8'h03}) begin
      n_fail++; $display("FAIL b2b second: got lat=%0d cout=%b sum=%h want lat=%0d cout=0 sum=03",
                         lat, cout, sum, W + 1);
    end
    @(negedge clk);
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1);
    run_op("sub_07_05", 8'h07, 8'h05, 1'b1, 1'b1);
    run_op("sub_equal", 8'h5A, 8'h5A, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_carry_chain();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_add_ctrl
